// File: rtl/bus_arbiter_rr_n.sv
// Round-robin bus arbiter for NUM_MASTERS masters with an optional tenure limit
// (MAX_HOLD) and a per-master lock that lets the current owner defer handover.
module bus_arbiter_rr_n #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req_,
  input  logic [NUM_MASTERS-1:0] lock_,
  output logic [NUM_MASTERS-1:0] grnt_,
  output logic [OWNER_W-1:0]     owner
);

  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_TOP = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  logic [OWNER_W-1:0]     r_owner;
  logic [CNT_W-1:0]       r_hold_cnt;

  logic [NUM_MASTERS-1:0] w_owner_1hot;
  logic                   w_req_own;
  logic                   w_lock_own;
  logic                   w_others;
  logic                   w_at_top;
  logic [OWNER_W-1:0]     w_search;
  logic [OWNER_W-1:0]     w_owner_nxt;
  logic [CNT_W-1:0]       w_hold_nxt;

  // First requester after the current owner in cyclic order; the owner itself is never a candidate.
  function automatic logic [OWNER_W-1:0] f_next_owner(input logic [OWNER_W-1:0]     cur,
                                                       input logic [NUM_MASTERS-1:0] req_n);
    logic [OWNER_W-1:0] sel;
    int                 cand;
    sel = cur;
    for (int i = NUM_MASTERS - 1; i >= 1; i--) begin
      cand = int'(cur) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!req_n[cand[OWNER_W-1:0]]) sel = cand[OWNER_W-1:0];
    end
    return sel;
  endfunction

  assign w_owner_1hot = NUM_MASTERS'(1) << r_owner;
  assign w_req_own    = ~req_[r_owner];
  assign w_lock_own   = ~lock_[r_owner];
  assign w_others     = |(~req_ & ~w_owner_1hot);
  assign w_at_top     = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_TOP);
  assign w_search     = f_next_owner(r_owner, req_);

  always_comb begin
    w_owner_nxt = r_owner;
    w_hold_nxt  = '0;
    if (w_req_own) begin
      if (w_at_top && !w_lock_own && w_others) begin
        w_owner_nxt = w_search;
      end else if (MAX_HOLD != 0) begin
        w_hold_nxt = w_at_top ? HOLD_TOP : r_hold_cnt + CNT_W'(1);
      end
    end else if (w_others) begin
      w_owner_nxt = w_search;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Grant decoded purely from registered state: no combinational req_/lock_ path.
  assign grnt_ = ~w_owner_1hot;
  assign owner = r_owner;

endmodule

// File: tb/tb_bus_arbiter_rr_n.sv
// Directed bench for bus_arbiter_rr_n: four instances with MAX_HOLD = 16, 0, 4, 1
// sharing stimulus; each test task checks the instance it targets.
module tb_bus_arbiter_rr_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_ = 4'b1111;
  logic [3:0] lock_ = 4'b1111;

  logic [3:0] g16, g0, g4, g1;
  logic [1:0] o16, o0, o4, o1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr_n #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(16)) u_h16 (
    .clk(clk), .reset(reset), .req_(req_), .lock_(lock_), .grnt_(g16), .owner(o16));
  bus_arbiter_rr_n #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(0)) u_h0 (
    .clk(clk), .reset(reset), .req_(req_), .lock_(lock_), .grnt_(g0), .owner(o0));
  bus_arbiter_rr_n #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(4)) u_h4 (
    .clk(clk), .reset(reset), .req_(req_), .lock_(lock_), .grnt_(g4), .owner(o4));
  bus_arbiter_rr_n #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(1)) u_h1 (
    .clk(clk), .reset(reset), .req_(req_), .lock_(lock_), .grnt_(g1), .owner(o1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held across one edge, released 2 time units after that edge.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_  = 4'b0000;
    lock_ = 4'b1111;
    reset = 1'b1;
    #1;
    checks++;
    if (g16 !== 4'b1110 || o16 !== 2'd0) begin
      failures++;
      $display("FAIL reset_async grnt_=%b owner=%0d expected grnt_=1110 owner=0", g16, o16);
    end
    tick();
    tick();
    checks++;
    if (g16 !== 4'b1110 || o16 !== 2'd0) begin
      failures++;
      $display("FAIL reset_held grnt_=%b owner=%0d expected grnt_=1110 owner=0", g16, o16);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (g16 !== 4'b1110 || o16 !== 2'd0) begin
        failures++;
        $display("FAIL reset_keep cyc=%0d grnt_=%b owner=%0d expected grnt_=1110 owner=0", k, g16, o16);
      end
    end
  endtask

  task automatic test_single_req();
    req_  = 4'b1111;
    lock_ = 4'b1111;
    do_reset();
    req_ = 4'b1011;
    tick();
    checks++;
    if (g16 !== 4'b1011 || o16 !== 2'd2) begin
      failures++;
      $display("FAIL single_req grnt_=%b owner=%0d expected grnt_=1011 owner=2", g16, o16);
    end
    req_ = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (g16 !== 4'b1011 || o16 !== 2'd2) begin
        failures++;
        $display("FAIL park cyc=%0d grnt_=%b owner=%0d expected grnt_=1011 owner=2", k, g16, o16);
      end
    end
  endtask

  task automatic test_wrap_unlimited();
    req_  = 4'b1111;
    lock_ = 4'b1111;
    do_reset();
    req_ = 4'b0111;
    tick();
    checks++;
    if (o0 !== 2'd3 || g0 !== 4'b0111) begin
      failures++;
      $display("FAIL h0_to3 grnt_=%b owner=%0d expected grnt_=0111 owner=3", g0, o0);
    end
    req_ = 4'b1001;
    tick();
    checks++;
    if (o0 !== 2'd1 || g0 !== 4'b1101) begin
      failures++;
      $display("FAIL h0_wrap grnt_=%b owner=%0d expected grnt_=1101 owner=1", g0, o0);
    end
    req_ = 4'b0000;
    for (int k = 0; k < 24; k++) begin
      tick();
      checks++;
      if (o0 !== 2'd1) begin
        failures++;
        $display("FAIL h0_hold_forever cyc=%0d owner=%0d expected 1", k, o0);
      end
    end
  endtask

  task automatic test_tenure();
    logic [1:0] exp;
    req_  = 4'b0000;
    lock_ = 4'b1111;
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      exp = 2'((k / 4) % 4);
      checks++;
      if (o4 !== exp || g4 !== ~(4'b0001 << exp)) begin
        failures++;
        $display("FAIL tenure k=%0d grnt_=%b owner=%0d expected owner=%0d", k, g4, o4, exp);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    req_  = 4'b1111;
    lock_ = 4'b1111;
    do_reset();
    req_ = 4'b1101;
    tick();
    checks++;
    if (o4 !== 2'd1) begin
      failures++;
      $display("FAIL lock_setup owner=%0d expected 1", o4);
    end
    req_  = 4'b0000;
    lock_ = 4'b1101;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (o4 !== 2'd1) begin
        failures++;
        $display("FAIL lock_hold cyc=%0d owner=%0d expected 1", k, o4);
      end
    end
    lock_ = 4'b1111;
    tick();
    checks++;
    if (o4 !== 2'd2 || g4 !== 4'b1011) begin
      failures++;
      $display("FAIL lock_release grnt_=%b owner=%0d expected grnt_=1011 owner=2", g4, o4);
    end
    // Lock on the owner whose request is high has no effect: plain release.
    req_  = 4'b1111;
    lock_ = 4'b1111;
    do_reset();
    req_  = 4'b0001;
    lock_ = 4'b1110;
    tick();
    checks++;
    if (o4 !== 2'd1) begin
      failures++;
      $display("FAIL lock_ignored_noreq owner=%0d expected 1", o4);
    end
    // Lock on a non-owner does not extend the owner's tenure.
    do_reset();
    req_  = 4'b0000;
    lock_ = 4'b1101;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (o4 !== 2'd1) begin
      failures++;
      $display("FAIL lock_non_owner owner=%0d expected 1", o4);
    end
    lock_ = 4'b1111;
  endtask

  task automatic test_async_mid_tenure();
    req_  = 4'b1111;
    lock_ = 4'b1111;
    do_reset();
    req_ = 4'b1011;
    tick();
    req_ = 4'b0000;
    tick();
    tick();
    checks++;
    if (o4 !== 2'd2) begin
      failures++;
      $display("FAIL async_setup owner=%0d expected 2", o4);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (g4 !== 4'b1110 || o4 !== 2'd0) begin
      failures++;
      $display("FAIL async_reset grnt_=%b owner=%0d expected grnt_=1110 owner=0", g4, o4);
    end
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (o4 !== ((k == 4) ? 2'd1 : 2'd0)) begin
        failures++;
        $display("FAIL async_restart edge=%0d owner=%0d expected %0d", k, o4, (k == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    req_  = 4'b0000;
    lock_ = 4'b1111;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (o1 !== 2'(k % 4)) begin
        failures++;
        $display("FAIL rotate_h1 edge=%0d owner=%0d expected %0d", k, o1, k % 4);
      end
    end
    // Owner drops and the next master is requesting in the same cycle: no idle edge.
    req_ = 4'b1111;
    do_reset();
    req_ = 4'b1110;
    tick();
    req_ = 4'b1101;
    tick();
    checks++;
    if (o16 !== 2'd1 || g16 !== 4'b1101) begin
      failures++;
      $display("FAIL handover grnt_=%b owner=%0d expected grnt_=1101 owner=1", g16, o16);
    end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_wrap_unlimited();
    test_tenure();
    test_lock();
    test_async_mid_tenure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
